// File: rtl/seq_alu_accum.sv
// Handshaked ALU with a 2N-bit accumulator and a multi-cycle restoring signed divider.
// Non-divide commands complete at the accepting edge; divides iterate one quotient bit per cycle.
module seq_alu_accum #(
  parameter int N = 16
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [4:0]     CMD,
  input  logic [N-1:0]   A,
  input  logic [N-1:0]   B,
  output logic [2*N-1:0] AccOut,
  output logic           out_valid,
  output logic           busy,
  output logic           overflow,
  output logic           divByZero
);

  localparam int          ACC_W   = 2 * N;
  localparam int          CNT_W   = $clog2(N);
  localparam logic [31:0] ACC_W32 = 32'(ACC_W);

  localparam logic [3:0] OP_ADD  = 4'd1,  OP_SUB  = 4'd2,  OP_MUL  = 4'd3,  OP_DIV = 4'd4;
  localparam logic [3:0] OP_SR   = 4'd5,  OP_SL   = 4'd6,  OP_AND  = 4'd7,  OP_OR  = 4'd8;
  localparam logic [3:0] OP_XOR  = 4'd9,  OP_NOT  = 4'd10, OP_NAND = 4'd11, OP_NOR = 4'd12;
  localparam logic [3:0] OP_XNOR = 4'd13, OP_CLR  = 4'd14;

  typedef enum logic {S_IDLE, S_DIV} state_e;

  state_e             state_q, state_d;
  logic               started_q;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic               vld_q, vld_d;
  logic               ovf_q, ovf_d;
  logic               dbz_q, dbz_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [N-1:0]       quo_q, quo_d;
  logic [N-1:0]       rem_q, rem_d;
  logic [N-1:0]       dvs_q, dvs_d;
  logic               neg_q, neg_d;

  // True when a sign-extended ACC_W value also fits in N signed bits.
  function automatic logic fits_n(input logic [ACC_W-1:0] v);
    logic [N:0] top;
    top = v[ACC_W-1:N-1];
    return (&top) | ~(|top);
  endfunction

  logic                    accept;
  logic [N-1:0]            b_eff;
  logic signed [N-1:0]     a_s, b_s;
  logic signed [N:0]       sum_s, dif_s;
  logic signed [ACC_W-1:0] prod_s;
  logic [ACC_W-1:0]        a_zx, shl, shr;
  logic                    sh_big;
  logic [N-1:0]            a_mag, b_mag;

  assign in_ready = started_q && (state_q == S_IDLE);
  assign accept   = in_valid && in_ready;
  assign b_eff    = CMD[4] ? acc_q[N-1:0] : B;
  assign a_s      = A;
  assign b_s      = b_eff;
  assign sum_s    = a_s + b_s;
  assign dif_s    = a_s - b_s;
  assign prod_s   = a_s * b_s;
  assign a_zx     = {{N{1'b0}}, A};
  assign sh_big   = ({32'd0, b_eff} >= {{N{1'b0}}, ACC_W32});
  assign shl      = sh_big ? '0 : (a_zx << b_eff);
  assign shr      = sh_big ? '0 : (a_zx >> b_eff);
  assign a_mag    = A[N-1] ? -A : A;
  assign b_mag    = b_eff[N-1] ? -b_eff : b_eff;

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  logic [N:0]       rem_sh, trial;
  logic [N-1:0]     quo_nx, rem_nx;
  logic [ACC_W-1:0] q_zx, div_res;

  assign rem_sh  = {rem_q, quo_q[N-1]};
  assign trial   = rem_sh - {1'b0, dvs_q};
  assign quo_nx  = {quo_q[N-2:0], ~trial[N]};
  assign rem_nx  = trial[N] ? rem_sh[N-1:0] : trial[N-1:0];
  assign q_zx    = {{N{1'b0}}, quo_nx};
  assign div_res = neg_q ? -q_zx : q_zx;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    vld_d   = 1'b0;
    ovf_d   = ovf_q;
    dbz_d   = dbz_q;
    cnt_d   = cnt_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dvs_d   = dvs_q;
    neg_d   = neg_q;
    if (state_q == S_IDLE) begin
      if (accept) begin
        vld_d = 1'b1;
        ovf_d = 1'b0;
        dbz_d = 1'b0;
        case (CMD[3:0])
          OP_ADD:  begin acc_d = {{(N-1){sum_s[N]}}, sum_s}; ovf_d = ~fits_n(acc_d); end
          OP_SUB:  begin acc_d = {{(N-1){dif_s[N]}}, dif_s}; ovf_d = ~fits_n(acc_d); end
          OP_MUL:  begin acc_d = prod_s; ovf_d = ~fits_n(prod_s); end
          OP_DIV: begin
            if (b_eff == '0) begin
              dbz_d = 1'b1;
            end else begin
              vld_d   = 1'b0;
              state_d = S_DIV;
              quo_d   = a_mag;
              rem_d   = '0;
              dvs_d   = b_mag;
              neg_d   = A[N-1] ^ b_eff[N-1];
              cnt_d   = '0;
            end
          end
          OP_SR:   acc_d = shr;
          OP_SL:   begin acc_d = shl; ovf_d = |shl[ACC_W-1:N]; end
          OP_AND:  acc_d = {{N{1'b0}}, A & b_eff};
          OP_OR:   acc_d = {{N{1'b0}}, A | b_eff};
          OP_XOR:  acc_d = {{N{1'b0}}, A ^ b_eff};
          OP_NOT:  acc_d = {{N{1'b0}}, ~A};
          OP_NAND: acc_d = {{N{1'b0}}, ~(A & b_eff)};
          OP_NOR:  acc_d = {{N{1'b0}}, ~(A | b_eff)};
          OP_XNOR: acc_d = {{N{1'b0}}, ~(A ^ b_eff)};
          OP_CLR:  acc_d = '0;
          default: ;
        endcase
      end
    end else begin
      quo_d = quo_nx;
      rem_d = rem_nx;
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == CNT_W'(N - 1)) begin
        // Only -2^(N-1) / -1 yields a positive quotient with the top bit set.
        acc_d   = div_res;
        ovf_d   = ~neg_q & quo_nx[N-1];
        dbz_d   = 1'b0;
        vld_d   = 1'b1;
        state_d = S_IDLE;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= S_IDLE;
      started_q <= 1'b0;
      acc_q     <= '0;
      vld_q     <= 1'b0;
      ovf_q     <= 1'b0;
      dbz_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      started_q <= 1'b1;
      acc_q     <= acc_d;
      vld_q     <= vld_d;
      ovf_q     <= ovf_d;
      dbz_q     <= dbz_d;
    end
  end

  always_ff @(posedge CLK) begin
    cnt_q <= cnt_d;
    quo_q <= quo_d;
    rem_q <= rem_d;
    dvs_q <= dvs_d;
    neg_q <= neg_d;
  end

  assign AccOut    = acc_q;
  assign out_valid = vld_q;
  assign busy      = (state_q == S_DIV);
  assign overflow  = ovf_q;
  assign divByZero = dbz_q;

endmodule

// File: tb/tb_seq_alu_accum.sv
// Randomized and directed bench for seq_alu_accum (N=16) against an integer-arithmetic reference model.
module tb_seq_alu_accum;

  logic        CLK = 1'b0;
  logic        RST;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  CMD;
  logic [15:0] A, B;
  logic [31:0] AccOut;
  logic        out_valid, busy, overflow, divByZero;

  int          total = 0;
  int          bad   = 0;
  logic [31:0] acc_m;

  seq_alu_accum #(.N(16)) dut (
    .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_ready(in_ready),
    .CMD(CMD), .A(A), .B(B), .AccOut(AccOut), .out_valid(out_valid),
    .busy(busy), .overflow(overflow), .divByZero(divByZero)
  );

  always #5 CLK = ~CLK;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference: results from plain integer arithmetic on the command's meaning.
  function automatic void model(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                                input logic [31:0] acc_in, output logic [31:0] r,
                                output bit ovf, output bit dbz, output bit multi);
    int sa, sb, v;
    logic [31:0] ua, ub;
    sa = $signed(a);
    sb = $signed(b);
    ua = {16'd0, a};
    ub = {16'd0, b};
    r = acc_in; ovf = 0; dbz = 0; multi = 0;
    case (op)
      4'd1: begin v = sa + sb; r = v; ovf = (v > 32767) || (v < -32768); end
      4'd2: begin v = sa - sb; r = v; ovf = (v > 32767) || (v < -32768); end
      4'd3: begin v = sa * sb; r = v; ovf = (v > 32767) || (v < -32768); end
      4'd4: begin
        if (sb == 0) dbz = 1;
        else begin
          multi = 1;
          if (sa == -32768 && sb == -1) begin r = 32'd32768; ovf = 1; end
          else r = sa / sb;
        end
      end
      4'd5: r = (ub >= 32) ? 32'd0 : (ua >> ub);
      4'd6: begin r = (ub >= 32) ? 32'd0 : (ua << ub); ovf = (r[31:16] != 16'd0); end
      4'd7:  r = ua & ub;
      4'd8:  r = ua | ub;
      4'd9:  r = ua ^ ub;
      4'd10: r = {16'd0, ~a};
      4'd11: r = {16'd0, ~(a & b)};
      4'd12: r = {16'd0, ~(a | b)};
      4'd13: r = {16'd0, ~(a ^ b)};
      4'd14: r = 32'd0;
      default: ;
    endcase
  endfunction

  task automatic do_cmd(input logic [4:0] cmd, input logic [15:0] a, input logic [15:0] b);
    logic [15:0] beff;
    logic [31:0] e_acc;
    bit e_ovf, e_dbz, multi;
    beff = cmd[4] ? acc_m[15:0] : b;
    model(cmd[3:0], a, beff, acc_m, e_acc, e_ovf, e_dbz, multi);
    chk("ready_before", {31'd0, in_ready}, 32'd1);
    CMD = cmd; A = a; B = b; in_valid = 1'b1;
    @(posedge CLK); #1;
    in_valid = 1'b0; CMD = 5'($urandom); A = 16'($urandom); B = 16'($urandom);
    if (multi) begin
      for (int i = 0; i < 16; i++) begin
        chk("div_busy", {31'd0, busy}, 32'd1);
        chk("div_ready", {31'd0, in_ready}, 32'd0);
        chk("div_vld", {31'd0, out_valid}, 32'd0);
        in_valid = (i < 15);
        CMD = 5'($urandom); A = 16'($urandom); B = 16'($urandom);
        @(posedge CLK); #1;
      end
      in_valid = 1'b0;
    end
    chk("out_valid", {31'd0, out_valid}, 32'd1);
    chk("acc", AccOut, e_acc);
    chk("ovf", {31'd0, overflow}, {31'd0, e_ovf});
    chk("dbz", {31'd0, divByZero}, {31'd0, e_dbz});
    chk("busy_done", {31'd0, busy}, 32'd0);
    chk("ready_done", {31'd0, in_ready}, 32'd1);
    acc_m = e_acc;
    @(posedge CLK); #1;
    chk("pulse_end", {31'd0, out_valid}, 32'd0);
  endtask

  function automatic logic [15:0] pick_val();
    case ($urandom_range(0, 7))
      0: return 16'h8000;
      1: return 16'h7FFF;
      2: return 16'hFFFF;
      3: return 16'h0000;
      4: return 16'($urandom_range(0, 40));
      default: return 16'($urandom);
    endcase
  endfunction

  initial begin
    logic [4:0]  rc;
    logic [15:0] ra, rb;
    RST = 1'b1; in_valid = 1'b1; CMD = 5'd1; A = 16'd10; B = 16'd20;
    acc_m = 32'd0;
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_acc", AccOut, 32'd0);
    chk("rst_vld", {31'd0, out_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_ovf", {31'd0, overflow}, 32'd0);
    chk("rst_dbz", {31'd0, divByZero}, 32'd0);
    chk("rst_ready", {31'd0, in_ready}, 32'd0);
    RST = 1'b0; in_valid = 1'b0;
    @(posedge CLK); #1;
    chk("post_rst_ready", {31'd0, in_ready}, 32'd1);
    chk("post_rst_vld", {31'd0, out_valid}, 32'd0);

    do_cmd(5'd0, 16'd0, 16'd0);
    chk("lit_nop", AccOut, 32'd0);
    do_cmd(5'd1, 16'd10, 16'd20);
    chk("lit_add", AccOut, 32'd30);
    do_cmd(5'b10001, 16'd5, 16'd999);
    chk("lit_accum", AccOut, 32'd35);
    do_cmd(5'd4, 16'd9, 16'd0);
    chk("lit_dbz_acc", AccOut, 32'd35);
    chk("lit_dbz", {31'd0, divByZero}, 32'd1);
    do_cmd(5'd1, 16'd1, 16'd1);
    chk("lit_after_dbz", AccOut, 32'd2);
    do_cmd(5'd1, 16'd30000, 16'd30000);
    chk("lit_add_ovf", AccOut, 32'h0000EA60);
    chk("lit_add_ovf_flag", {31'd0, overflow}, 32'd1);
    do_cmd(5'd3, -16'sd300, 16'd200);
    chk("lit_mul", AccOut, 32'hFFFF15A0);
    do_cmd(5'd6, 16'd16, 16'd2);
    chk("lit_sl", AccOut, 32'd64);
    do_cmd(5'd14, 16'd7, 16'd7);
    chk("lit_clr", AccOut, 32'd0);
    do_cmd(5'd6, 16'd1, 16'd40);
    chk("lit_sl_big", AccOut, 32'd0);
    do_cmd(5'd4, -16'sd100, 16'd7);
    chk("lit_div", AccOut, 32'hFFFFFFF2);
    do_cmd(5'd4, 16'h8000, 16'hFFFF);
    chk("lit_div_ovf", AccOut, 32'h00008000);
    do_cmd(5'd6, 16'h0001, 16'd31);

    // Reset arriving during the fifth divide cycle aborts the operation.
    CMD = 5'd4; A = -16'sd100; B = 16'd7; in_valid = 1'b1;
    @(posedge CLK); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge CLK);
    #1;
    chk("mid_busy", {31'd0, busy}, 32'd1);
    RST = 1'b1;
    @(posedge CLK); #1;
    chk("abort_acc", AccOut, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_vld", {31'd0, out_valid}, 32'd0);
    chk("abort_ready", {31'd0, in_ready}, 32'd0);
    RST = 1'b0;
    acc_m = 32'd0;
    for (int i = 0; i < 18; i++) begin
      @(posedge CLK); #1;
      chk("abort_no_vld", {31'd0, out_valid}, 32'd0);
      chk("abort_ready_after", {31'd0, in_ready}, 32'd1);
    end

    for (int n = 0; n < 300; n++) begin
      rc = 5'($urandom_range(0, 15));
      rc[4] = ($urandom_range(0, 3) == 0);
      ra = pick_val();
      rb = pick_val();
      if (rc[3:0] == 4'd4 && $urandom_range(0, 5) == 0) rb = 16'd0;
      do_cmd(rc, ra, rb);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
